regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between the ALU writeback stage and load-return data from the LSU.
- Keeps a per-register pending-load scoreboard and produces the decode-stage hazard stall.
- Sits between the execute/LSU stages and the 16-entry RV32E register file: drives its we/rd/rd_data inputs and observes decode's source and destination indices.

---
 rtl/regfile_wb_arbiter.sv | 90 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the register-file write port between ALU writeback and buffered load returns, tracks pending loads and stalls decode
// Ports: clk/rst_n (async active-low); alu_valid/alu_rd/alu_data -> alu_ready;
//        ld_valid/ld_rd/ld_data -> ld_ready; iss_ld/iss_rd scoreboard set;
//        dec_rs1/dec_rs2/dec_rd -> hazard; rf_we/rf_rd/rf_data write port; err sticky.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int LQ_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [3:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [3:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic            iss_ld,
  input  logic [3:0]      iss_rd,
  input  logic [3:0]      dec_rs1,
  input  logic [3:0]      dec_rs2,
  input  logic [3:0]      dec_rd,
  output logic            hazard,
  output logic            rf_we,
  output logic [3:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            err
);
  localparam int AW = $clog2(LQ_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [AW:0]      wr_q, rd_q;
  logic [3:0]       mem_rd_q [LQ_DEPTH];
  logic [XLEN-1:0]  mem_data_q [LQ_DEPTH];
  logic [SW-1:0]    starve_q, starve_d;
  logic [15:0]      pend_q, pend_d, set_v, clr_v;
  logic             err_q, err_d;
  logic             empty, full, push, ld_gnt, alu_gnt;
  logic [3:0]       head_rd;
  logic [XLEN-1:0]  head_data;
  assign empty     = wr_q == rd_q;
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_rd   = mem_rd_q[rd_q[AW-1:0]];
  assign head_data = mem_data_q[rd_q[AW-1:0]];
  assign ld_ready  = !full;
  assign push      = ld_valid && ld_ready;
  // a waiting load wins when the ALU is idle or has used up its starvation budget
  assign ld_gnt    = !empty && (starve_q == SW'(STARVE_LIMIT) || !alu_valid);
  assign alu_gnt   = !ld_gnt && alu_valid;
  assign alu_ready = alu_gnt;
  assign rf_rd     = ld_gnt ? head_rd : alu_gnt ? alu_rd : 4'd0;
  assign rf_data   = ld_gnt ? head_data : alu_gnt ? alu_data : '0;
  assign rf_we     = (ld_gnt || alu_gnt) && rf_rd != 4'd0;
  assign hazard    = pend_q[dec_rs1] || pend_q[dec_rs2] || pend_q[dec_rd];
  assign err       = err_q;
  always_comb begin
    set_v    = 16'(iss_ld) << iss_rd;
    clr_v    = 16'(ld_gnt) << head_rd;
    // set is applied after clear so a same-cycle reissue keeps the bit; x0 never pends
    pend_d   = ((pend_q & ~clr_v) | set_v) & 16'hFFFE;
    starve_d = (ld_gnt || empty) ? '0 :
               (alu_gnt && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    err_d    = err_q
             || (alu_gnt && alu_rd != 4'd0 && pend_q[alu_rd])
             || (ld_gnt && !pend_q[head_rd])
             || (iss_ld && iss_rd != 4'd0 && pend_q[iss_rd] && !clr_v[iss_rd]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      starve_q <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_q     <= wr_q + (AW+1)'(push);
      rd_q     <= rd_q + (AW+1)'(ld_gnt);
      starve_q <= starve_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_q[AW-1:0]]   <= ld_rd;
      mem_data_q[wr_q[AW-1:0]] <= ld_data;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of regfile_wb_arbiter against a queue-based model
module tb_regfile_wb_arbiter;
  localparam int LIM = 4;
  localparam int DEPTH = 2;
  logic        clk = 0, rst_n = 0;
  logic        alu_valid, ld_valid, iss_ld;
  logic [3:0]  alu_rd, ld_rd, iss_rd, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, hazard, rf_we, err;
  logic [3:0]  rf_rd;
  logic [31:0] rf_data;
  int          checks = 0, fails = 0;
  logic [35:0] lq[$];
  logic [15:0] pend;
  int          starve;
  logic        err_m, e_lg, e_ag, e_ready;
  logic [3:0]  wlog[$];
  regfile_wb_arbiter #(.XLEN(32), .LQ_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .iss_ld(iss_ld), .iss_rd(iss_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .hazard(hazard),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
    end
  endtask
  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    iss_ld = 0; iss_rd = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask
  task automatic settle();
    logic [3:0]  erd;
    logic [31:0] edata;
    #1;
    e_ready = lq.size() < DEPTH;
    e_lg    = lq.size() != 0 && (starve == LIM || !alu_valid);
    e_ag    = !e_lg && alu_valid;
    erd     = e_lg ? lq[0][35:32] : e_ag ? alu_rd : 4'd0;
    edata   = e_lg ? lq[0][31:0] : e_ag ? alu_data : 32'd0;
    chk("ld_ready", ld_ready, e_ready);
    chk("alu_ready", alu_ready, e_ag);
    chk("rf_we", rf_we, (e_lg || e_ag) && erd != 0);
    chk("rf_rd", rf_rd, erd);
    chk("rf_data", rf_data, edata);
    chk("hazard", hazard, (dec_rs1 != 0 && pend[dec_rs1]) || (dec_rs2 != 0 && pend[dec_rs2]) || (dec_rd != 0 && pend[dec_rd]));
    chk("err", err, err_m);
    if (rf_we && !alu_ready) wlog.push_back(rf_rd);
  endtask
  task automatic tick();
    logic [15:0] old;
    logic [35:0] h;
    logic        was_ne;
    @(posedge clk);
    old = pend;
    was_ne = lq.size() != 0;
    h = '0;
    if (e_ag && alu_rd != 0 && old[alu_rd]) err_m = 1;
    if (e_lg) begin
      h = lq.pop_front();
      if (!old[h[35:32]]) err_m = 1;
      pend[h[35:32]] = 0;
    end
    if (iss_ld && iss_rd != 0) begin
      if (old[iss_rd] && !(e_lg && h[35:32] == iss_rd)) err_m = 1;
      pend[iss_rd] = 1;
    end
    if (ld_valid && e_ready) lq.push_back({ld_rd, ld_data});
    starve = (e_lg || !was_ne) ? 0 : e_ag ? (starve + 1 > LIM ? LIM : starve + 1) : starve;
    @(negedge clk);
  endtask
  task automatic do_reset();
    #2 rst_n = 0;
    idle_inputs();
    lq.delete(); pend = 0; starve = 0; err_m = 0;
    repeat (3) @(negedge clk);
    settle();
    rst_n = 1;
  endtask
  initial begin
    logic acc;
    idle_inputs();
    @(negedge clk);
    do_reset();
    settle(); tick();
    // scoreboard
    iss_ld = 1; iss_rd = 5; settle(); tick();
    iss_ld = 0; dec_rs1 = 5; settle(); chk("haz_set", hazard, 1); tick();
    ld_valid = 1; ld_rd = 5; ld_data = 32'hDEADBEEF; settle(); tick();
    ld_valid = 0; settle();
    chk("ld5_we", rf_we, 1); chk("ld5_rd", rf_rd, 5); chk("ld5_data", rf_data, 32'hDEADBEEF);
    chk("haz_wb", hazard, 1); tick();
    settle(); chk("haz_clr", hazard, 0); tick();
    // starvation
    iss_ld = 1; iss_rd = 3; settle(); tick();
    iss_ld = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    ld_valid = 1; ld_rd = 3; ld_data = 32'h3333; settle(); tick();
    ld_valid = 0;
    for (int i = 0; i < LIM; i++) begin settle(); chk("starve_alu", alu_ready, 1); tick(); end
    settle(); chk("starve_ld", alu_ready, 0); chk("starve_rd", rf_rd, 3); tick();
    settle(); chk("starve_resume", alu_ready, 1); tick();
    // FIFO full and ordering
    alu_valid = 0; wlog.delete();
    iss_ld = 1; iss_rd = 2; settle(); tick();
    iss_rd = 4; settle(); tick();
    iss_rd = 6; settle(); tick();
    iss_ld = 0; alu_valid = 1;
    ld_valid = 1; ld_rd = 2; ld_data = 32'h2222; settle(); tick();
    ld_rd = 4; ld_data = 32'h4444; settle(); tick();
    ld_rd = 6; ld_data = 32'h6666; settle(); chk("full_ready", ld_ready, 0); tick();
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) begin settle(); acc = ld_ready; tick(); end
    chk("third_accept", acc, 1);
    ld_valid = 0; alu_valid = 0;
    repeat (6) begin settle(); tick(); end
    chk("order_n", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("order0", wlog[0], 2); chk("order1", wlog[1], 4); chk("order2", wlog[2], 6);
    end
    // x0 handling
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; settle();
    chk("x0_ready", alu_ready, 1); chk("x0_we", rf_we, 0); tick();
    alu_valid = 0; iss_ld = 1; iss_rd = 0; settle(); tick();
    iss_ld = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; settle(); chk("x0_haz", hazard, 0); tick();
    // error
    chk("err_pre", err, 0);
    iss_ld = 1; iss_rd = 9; settle(); tick();
    iss_ld = 0; alu_valid = 1; alu_rd = 9; settle(); tick();
    alu_valid = 0;
    repeat (3) begin settle(); chk("err_sticky", err, 1); tick(); end
    do_reset();
    chk("err_cleared", err, 0);
    // random traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      alu_valid = $urandom_range(0, 9) < 6; alu_rd = 4'($urandom); alu_data = $urandom;
      ld_valid = $urandom_range(0, 9) < 3; ld_rd = 4'($urandom); ld_data = $urandom;
      iss_ld = $urandom_range(0, 9) < 2; iss_rd = 4'($urandom);
      dec_rs1 = 4'($urandom); dec_rs2 = 4'($urandom); dec_rd = 4'($urandom);
      settle(); tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
